dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the 5-stage RISC-V pipeline.
- Accepts one load/store request at a time from the MEM stage and returns load data after a fixed multi-cycle latency.
- Drives `stall` so that the MEM/WB register enable (`enable = ~stall`) holds the pipeline until the response arrives.
- Is the memory-side end of the interface whose results the MEM/WB register latches as `mem_data_out_mem`.

Parameters:
- DEPTH, 1024, number of 32-bit words in the internal array; power of two.
- LATENCY, 2, clock edges from request acceptance to `resp_valid`; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  MEM stage presents a request; held high until `resp_valid`.
- req_ready  output  1  responder can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse; response data valid.
- resp_rdata  output  32  extended load data; 0 for stores and for errors.
- resp_err  output  1  valid with `resp_valid`; only ever 1 when DMEM_MISALIGN_TRAP_EN is defined.
- stall  output  1  equals `req_valid & ~resp_valid`.

Behaviour:
- Reset (asynchronous, `rst_n = 0`):
  - state returns to IDLE; `cnt`, `resp_valid`, `resp_rdata` and `resp_err` are cleared to 0.
  - `req_ready` is 1 once reset is released.
  - Memory contents are not reset.
- Accept: at the rising edge with state IDLE and `req_valid = 1`.
- States:
  - IDLE -> RESP when a request is accepted and LATENCY = 1.
  - IDLE -> WAIT when a request is accepted and LATENCY > 1; `cnt` is loaded with LATENCY-2.
  - WAIT -> RESP when `cnt = 0`; otherwise WAIT holds and `cnt` decrements.
  - RESP -> IDLE unconditionally after one cycle.
- Timing:
  - `resp_valid` is high exactly in the RESP cycle, i.e. LATENCY edges after the accept edge.
  - Throughput is one request per LATENCY+1 cycles.
- Word index = `req_addr[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Stores: commit at the accept edge.
  - byte: lane `addr[1:0]` is written.
  - half: lanes `{addr[1],0}` and `{addr[1],1}` are written.
  - word: all four lanes are written.
  - Other lanes are untouched.
- Loads:
  - Lanes are extracted at the accept edge, shifted to bit 0, then zero- or sign-extended to 32 bits.
  - The result is held in a register and presented as `resp_rdata` in RESP.
- Store followed by load to the same address: the load returns the stored data, because the store commits before the load is accepted.
- Size 11 (reserved):
  - without the macro, treated as word;
  - with the macro, flagged as an error.
- `req_valid` dropped by the requester before the response: the transaction still completes with a RESP pulse; `stall` is 0 during that cycle.
- Reset mid-transaction:
  - the transaction is abandoned and no `resp_valid` is produced;
  - a store committed at its accept edge remains committed.
- `resp_rdata` and `resp_err` return to 0 outside RESP.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: the following requests are flagged as errors:
  - half access with `addr[0] = 1`;
  - word access with `addr[1:0] != 0`;
  - size 11.

  For a flagged request there is no memory write, `resp_rdata = 0` and `resp_err = 1` in RESP. Latency is unchanged.
- Undefined:
  - low address bits below the access size are ignored (forced aligned);
  - `resp_err` is tied to 0.

Test Plan:
1. Reset: hold `rst_n = 0` for 3 cycles with `req_valid = 1` -> `resp_valid = 0`, `resp_rdata = 0`, `stall = 1`; after release, `req_ready = 1`.
2. Word store then load (LATENCY = 2): store `0xFEEDF00D` at `0x40`, then load `0x40` -> `resp_valid` 2 edges after each accept; load gives `resp_rdata = 0xFEEDF00D`; `stall` is high for 2 cycles per access.
3. Sub-word loads from word `0x80F0_7F01` at `0x10`:
   - byte at `0x13`, signed -> `0xFFFFFF80`;
   - half at `0x10`, unsigned -> `0x00007F01`;
   - half at `0x12`, signed -> `0xFFFF80F0`.
4. Byte store `0xAB` to `0x21` over word `0x11223344` -> a later word load at `0x20` returns `0x1122AB44`.
5. Address wrap (DEPTH = 1024): store `0x5` at `0x1000`, load `0x0` -> `0x00000005`. Reset during WAIT of a load -> no `resp_valid` pulse.
6. With DMEM_MISALIGN_TRAP_EN defined: word store `0xDEADBEEF` to `0x42` -> `resp_err = 1`; a word load at `0x40` returns the previous contents. With the macro undefined, the same store writes word `0x40` and `resp_err = 0`.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM stage with fixed LATENCY.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_we/req_addr/req_size/req_unsigned/req_wdata
// request side; resp_valid/resp_rdata/resp_err response side; stall = req_valid & ~resp_valid.
// Optional: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word and size 11 as errors
// (no write, zero data, resp_err = 1); otherwise low address bits are ignored and resp_err is 0.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 2 ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT0 = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0] mem [DEPTH];
  logic [31:0] ld_q, sh, ext, wd;
  logic        err_q, err, accept;
  logic [AW-1:0] idx;
  logic [1:0]  off;
  logic [3:0]  be;
  // Full address shifted then truncated: upper bits wrap modulo 4*DEPTH bytes.
  assign idx    = AW'(req_addr >> 2);
  assign accept = (state == S_IDLE) & req_valid;
  // Lane offset of the (forced-aligned) access; size 11 behaves as word.
  assign off = req_size == 2'b00 ? req_addr[1:0] : req_size == 2'b01 ? {req_addr[1], 1'b0} : 2'b00;
  assign be  = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
               req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd  = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
               req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign sh  = mem[idx] >> {off, 3'b000};
  assign ext = req_size == 2'b00 ? {{24{~req_unsigned & sh[7]}}, sh[7:0]} :
               req_size == 2'b01 ? {{16{~req_unsigned & sh[15]}}, sh[15:0]} : sh;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign err = (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & |req_addr[1:0]) | (req_size == 2'b11);
`else
  assign err = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (req_valid) begin
        state_nx = LATENCY == 1 ? S_RESP : S_WAIT;
        cnt_nx   = CNT0;
      end
      S_WAIT: begin
        state_nx = cnt == '0 ? S_RESP : S_WAIT;
        cnt_nx   = cnt == '0 ? cnt : cnt - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      ld_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        ld_q  <= (req_we | err) ? '0 : ext;
        err_q <= err;
      end
    end
  // Memory is intentionally not reset; stores commit at the accept edge.
  always_ff @(posedge clk)
    if (accept & req_we & ~err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  assign req_ready  = state == S_IDLE;
  assign resp_valid = state == S_RESP;
  assign resp_rdata = resp_valid ? ld_q : '0;
  assign resp_err   = resp_valid & err_q;
  assign stall      = req_valid & ~resp_valid;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized + directed check of dmem_responder against a transaction-level model.
module tb_dmem_responder;
  localparam int LAT = 2;
  logic        clk = 0, rst_n = 1;
  logic        req_valid = 0, req_we = 0, req_unsigned = 0;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [1:0]  req_size = 0;
  int vectors = 0, miscompares = 0, pulses = 0;
  bit [31:0] mm [1024];
  bit        busy = 0, eerr = 0, cur_ev = 0;
  int        age = 0;
  bit [31:0] edata = 0, last_rdata = 0;
  bit        last_err = 0;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-transaction model: computes the response from the request using byte arithmetic.
  task automatic model_accept();
    int idx = int'((req_addr >> 2) % 1024);
    int lo = int'(req_addr % 4);
    int nb = req_size == 0 ? 1 : req_size == 1 ? 2 : 4;
    int off = lo - lo % nb;
    longint v;
    eerr = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    eerr = (nb == 2 && lo % 2 != 0) || (req_size == 2 && lo != 0) || req_size == 3;
`endif
    edata = 0;
    if (!eerr && req_we)
      for (int i = 0; i < nb; i++) mm[idx][8*(off+i) +: 8] = req_wdata[8*i +: 8];
    else if (!eerr) begin
      v = longint'(mm[idx]) >> (8 * off);
      v = v % (64'sd1 << (8 * nb));
      if (!req_unsigned && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
      edata = v[31:0];
    end
  endtask

  task automatic model_edge();
    if (!busy) begin
      if (req_valid) begin model_accept(); busy = 1; age = 1; end
    end else if (age == LAT) busy = 0;
    else age++;
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(negedge clk);
    cur_ev = busy && age == LAT;
    cmp("resp_valid", {31'b0, resp_valid}, {31'b0, cur_ev});
    cmp("req_ready", {31'b0, req_ready}, {31'b0, !busy});
    cmp("stall", {31'b0, stall}, {31'b0, req_valid & ~cur_ev});
    cmp("resp_rdata", resp_rdata, cur_ev ? edata : 32'h0);
    cmp("resp_err", {31'b0, resp_err}, {31'b0, cur_ev & eerr});
    if (resp_valid) begin last_rdata = resp_rdata; last_err = resp_err; pulses++; end
  endtask

  task automatic xact(input bit we, input bit [31:0] a, input bit [1:0] sz, input bit u, input bit [31:0] wd);
    int n = 0, p0 = pulses;
    req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd; req_valid = 1;
    do begin tick(); n++; end while (pulses == p0 && n < 20);
    cmp("latency", n, LAT);
    req_valid = 0;
    tick();
  endtask

  initial begin
    #2 rst_n = 0;
    req_valid = 1;
    @(negedge clk);
    busy = 0;
    repeat (3) tick();
    cmp("rst_stall", {31'b0, stall}, 1);
    cmp("rst_rdata", resp_rdata, 0);
    req_valid = 0; rst_n = 1;
    tick();
    cmp("rst_ready", {31'b0, req_ready}, 1);
    for (int w = 0; w < 32; w++) xact(1, w * 4, 2, 0, $urandom);
    xact(1, 32'h40, 2, 0, 32'hFEEDF00D);
    xact(0, 32'h40, 2, 0, 0);
    cmp("word_load", last_rdata, 32'hFEEDF00D);
    xact(1, 32'h10, 2, 0, 32'h80F07F01);
    xact(0, 32'h13, 0, 0, 0);
    cmp("byte_s", last_rdata, 32'hFFFFFF80);
    xact(0, 32'h10, 1, 1, 0);
    cmp("half_u", last_rdata, 32'h00007F01);
    xact(0, 32'h12, 1, 0, 0);
    cmp("half_s", last_rdata, 32'hFFFF80F0);
    xact(1, 32'h20, 2, 0, 32'h11223344);
    xact(1, 32'h21, 0, 0, 32'h000000AB);
    xact(0, 32'h20, 2, 0, 0);
    cmp("byte_merge", last_rdata, 32'h1122AB44);
    xact(1, 32'h1000, 2, 0, 32'h5);
    xact(0, 32'h0, 2, 0, 0);
    cmp("wrap", last_rdata, 32'h5);
    begin
      int p0;
      req_we = 0; req_addr = 32'h40; req_size = 2; req_valid = 1;
      tick();
      rst_n = 0; busy = 0; req_valid = 0; p0 = pulses;
      tick(); tick();
      rst_n = 1;
      tick(); tick();
      cmp("rst_abandon", pulses - p0, 0);
    end
    xact(1, 32'h42, 2, 0, 32'hDEADBEEF);
`ifdef DMEM_MISALIGN_TRAP_EN
    cmp("trap_err", {31'b0, last_err}, 1);
    xact(0, 32'h40, 2, 0, 0);
    cmp("trap_nowrite", last_rdata, 32'hFEEDF00D);
`else
    cmp("align_err", {31'b0, last_err}, 0);
    xact(0, 32'h40, 2, 0, 0);
    cmp("align_write", last_rdata, 32'hDEADBEEF);
`endif
    for (int c = 0; c < 2000; c++) begin
      if (!req_valid || cur_ev) begin
        req_valid = $urandom_range(0, 3) != 0;
        req_we = $urandom_range(0, 1) != 0;
        req_addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 127));
        req_size = 2'($urandom_range(0, 3));
        req_unsigned = $urandom_range(0, 1) != 0;
        req_wdata = $urandom;
      end else if ($urandom_range(0, 9) == 0) req_valid = 0;
      tick();
    end
    req_valid = 0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
